ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Shares the single CPU-side port of the dual-port video/data RAM between two requesters: requester 0 (the ALU/CPU datapath) and requester 1 (a DMA/loader engine). It sits between the requesters and the RAM's port A in the CPU clock domain. Each cycle it issues at most one access to the RAM and tracks in-flight reads so that each read datum is returned to the requester that issued it. It arbitrates round-robin, with an optional bounded lock (burst) per requester.

## Interface
- READ_LAT, 2, RAM read latency in cycles from an accepted read to valid ram_q (≥1)
- MAX_BURST, 8, maximum consecutive locked grants before a waiting requester must be served (≥1)
- ADDR_W, 16, address width
- DATA_W, 16, data width

- clock  in  1  CPU clock; all state on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  2  per-requester access request
- lock  in  2  per-requester request to keep ownership on following cycles
- we  in  2  per-requester write enable (1 = write, 0 = read)
- addr0, addr1  in  ADDR_W  requester addresses
- wdata0, wdata1  in  DATA_W  requester write data
- gnt  out  2  one-hot or zero; access accepted at the rising edge ending this cycle
- rvalid  out  2  per-requester read-data-valid strobe
- rdata  out  DATA_W  read data, shared, qualified by rvalid
- ram_address  out  ADDR_W  RAM port A address
- ram_data  out  DATA_W  RAM port A write data
- ram_wren  out  1  RAM port A write enable
- ram_q  in  DATA_W  RAM port A read data

## Operation
- State machine: IDLE, OWN0, OWN1 (registered). The rr pointer (1 bit) names the preferred requester on a conflict.
- IDLE or no lock continuing: grant the single requester asserting req. If both assert req, grant the one indicated by rr. Next state becomes OWNx of the grantee, and rr moves to the other requester.
- OWNx:
  - x keeps the grant while req[x] && lock[x] && burst_cnt < MAX_BURST, even if the other requester asserts req.
  - Once burst_cnt reaches MAX_BURST with the other requester pending, the other requester is granted that cycle.
  - If the other requester is not pending, x continues and burst_cnt restarts at 1.
  - If x drops req or lock, arbitration is as in IDLE.
  - With no request, the next state is IDLE.
- burst_cnt: counts consecutive grants to the current owner, starting at 1 on the first grant. It resets on an ownership change or an idle cycle.
- Handshake: a requester holds req, we, addr and wdata stable until it sees gnt high. The access is taken at that edge. req may stay high for back-to-back accesses.
- RAM drive, combinational:
  - ram_address and ram_data come from the granted requester; with no grant they come from requester 0.
  - ram_wren = gnt[i] && we[i]; it is 0 with no grant.
- Read tracking: a READ_LAT-deep shift register of {valid, id}, loaded on every granted read. A granted write loads valid = 0. At the tail, rvalid[id] = valid and rdata = ram_q.
- One access per cycle at most, so at most one rvalid bit is high in any cycle.

## Timing
- gnt is combinational from req, lock and registered state. There are no combinational paths from ram_q to gnt.
- Read granted in cycle t → rvalid[i] high only in cycle t+READ_LAT, with rdata = ram_q of that cycle.
- Write granted in cycle t → RAM written at the edge ending t. No rvalid is produced.
- Full throughput: one access per cycle. Back-to-back reads from alternating requesters return in issue order.
- Reset values: state IDLE, rr = 0, burst_cnt = 0, pipeline valid bits all 0.
- Outputs during reset: gnt = 0, rvalid = 0, ram_wren = 0 (forced, since req is ignored while reset_n is low).
- Reset mid-operation flushes in-flight reads; no rvalid is produced for them after reset is released.
- Simultaneous first requests after reset: requester 0 wins.

## Configuration
- ARB_STATS_EN defined: adds outputs stat_gnt0, stat_gnt1 and stat_stall, each 16 bits, saturating at 16'hFFFF and cleared by reset.
  - stat_gnt0 and stat_gnt1 count grants per requester.
  - stat_stall counts cycles in which some req is high and not granted.
- ARB_STATS_EN undefined: these ports and counters are absent, and arbitration behaviour is identical.

## Structure
- Shared package ram_arb_pkg holds the state enum (IDLE, OWN0, OWN1), the requester-id type and the pipeline entry struct {valid, id}.
- One sub-module: ram_read_tracker, the READ_LAT-deep {valid, id} shift register with an rvalid decode.

## Test plan
- Single requester read: req = 2'b01, we = 0, addr0 = 16'h0010 with RAM[0x10] = 16'hBEEF → gnt = 01 the same cycle; rvalid = 01 and rdata = 16'hBEEF exactly 2 cycles later.
- Simultaneous requests: both req high for 4 cycles, no lock → gnt sequence 01, 10, 01, 10.
- Lock burst: req1 and lock1 held, req0 held, MAX_BURST = 8 → gnt = 10 for 8 cycles, then 01 for 1 cycle, then 10.
- Write then read-back: requester 1 writes 16'h1234 to 0x0200, then requester 0 reads 0x0200 → rvalid = 01 with rdata = 16'h1234; no rvalid for the write.
- Reset mid-flight: read granted, then reset_n low for 1 cycle before the return → no rvalid at any time afterwards; state IDLE, gnt = 0 during reset.
- ARB_STATS_EN: 70000 cycles of contention → stat_stall saturates at 16'hFFFF; grant counts match the issued accesses.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port-A arbiter: FSM state encoding, requester id
// and the read-tracking pipeline entry.
package ram_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_OWN0 = 2'd1;
    localparam arb_state_t ST_OWN1 = 2'd2;

    // Requester 0 = CPU datapath, requester 1 = DMA/loader engine.
    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_entry_t;

endpackage

// File: rtl/ram_read_tracker.sv
// Tracks in-flight RAM reads for READ_LAT cycles so each returning datum is
// flagged to the requester that issued it. Writes enter as invalid entries.
module ram_read_tracker
    import ram_arb_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic      clock_i,
    input  logic      reset_ni,
    input  rd_entry_t entry_i,
    output logic [1:0] rvalid_o
);

    rd_entry_t [READ_LAT-1:0] pipe_q;
    rd_entry_t [READ_LAT-1:0] pipe_d;
    rd_entry_t                tail;

    // Shift every entry one stage towards the tail, new entry at stage 0.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = entry_i;
        for (int i = 1; i < READ_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline register; reset flushes every in-flight read.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tail = pipe_q[READ_LAT-1];

    // Decode the tail entry into a one-hot (or zero) read-valid strobe.
    always_comb begin
        rvalid_o = 2'b00;
        if (tail.valid) begin
            rvalid_o[tail.id] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing RAM port A between the CPU datapath (req 0)
// and a DMA/loader (req 1), with bounded lock bursts and read return routing.
// Optional feature macro: ARB_STATS_EN adds saturating grant/stall counters.
//
// Handshake: a requester raises req[i] with we/addr/wdata and holds them
// stable until it sees gnt[i] high; the access is taken at the rising edge
// that ends that cycle. req may remain high for back-to-back accesses.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int READ_LAT  = 2,
    parameter int MAX_BURST = 8,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        req,
    input  logic [1:0]        lock,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
`ifdef ARB_STATS_EN
    output logic [15:0]       stat_gnt0,
    output logic [15:0]       stat_gnt1,
    output logic [15:0]       stat_stall,
`endif
    output arb_state_t        dbg_state
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]       arb_gnt;
    logic             keep_own;
    logic             burst_at_max;
    rd_entry_t        rd_entry;

    assign burst_at_max = (burst_cnt_q >= CNT_W'(MAX_BURST));

    // Grant selection: a locked owner keeps the port until its burst budget
    // is spent with the other side waiting; otherwise plain round-robin.
    always_comb begin
        arb_gnt  = 2'b00;
        keep_own = 1'b0;
        if (state_q == ST_OWN0 && req[0] && lock[0]) begin
            keep_own = 1'b1;
            arb_gnt  = (burst_at_max && req[1]) ? 2'b10 : 2'b01;
        end else if (state_q == ST_OWN1 && req[1] && lock[1]) begin
            keep_own = 1'b1;
            arb_gnt  = (burst_at_max && req[0]) ? 2'b01 : 2'b10;
        end
        if (!keep_own) begin
            case (req)
                2'b01:   arb_gnt = 2'b01;
                2'b10:   arb_gnt = 2'b10;
                2'b11:   arb_gnt = rr_q ? 2'b10 : 2'b01;
                default: arb_gnt = 2'b00;
            endcase
        end
    end

    // Requests are ignored while reset is held.
    assign gnt = reset_n ? arb_gnt : 2'b00;

    // Next owner, round-robin pointer and consecutive-grant count.
    always_comb begin
        state_d     = ST_IDLE;
        rr_d        = rr_q;
        burst_cnt_d = '0;
        if (gnt[0]) begin
            state_d     = ST_OWN0;
            rr_d        = 1'b1;
            burst_cnt_d = (state_q != ST_OWN0) ? CNT_W'(1) :
                          (burst_at_max ? CNT_W'(1) : burst_cnt_q + CNT_W'(1));
        end else if (gnt[1]) begin
            state_d     = ST_OWN1;
            rr_d        = 1'b0;
            burst_cnt_d = (state_q != ST_OWN1) ? CNT_W'(1) :
                          (burst_at_max ? CNT_W'(1) : burst_cnt_q + CNT_W'(1));
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign dbg_state = state_q;

    // Port A drive; requester 0 supplies address/data when nobody is granted.
    assign ram_address = gnt[1] ? addr1  : addr0;
    assign ram_data    = gnt[1] ? wdata1 : wdata0;
    assign ram_wren    = |(gnt & we);

    assign rd_entry.valid = |(gnt & ~we);
    assign rd_entry.id    = gnt[1];

    ram_read_tracker #(
        .READ_LAT (READ_LAT)
    ) u_tracker (
        .clock_i  (clock),
        .reset_ni (reset_n),
        .entry_i  (rd_entry),
        .rvalid_o (rvalid)
    );

    assign rdata = ram_q;

`ifdef ARB_STATS_EN
    logic [15:0] stat_gnt0_q, stat_gnt1_q, stat_stall_q;
    logic        stalled;

    assign stalled = |(req & ~gnt);

    // Saturating grant and stall counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_gnt0_q  <= '0;
            stat_gnt1_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            if (gnt[0] && stat_gnt0_q != 16'hFFFF) stat_gnt0_q <= stat_gnt0_q + 16'd1;
            if (gnt[1] && stat_gnt1_q != 16'hFFFF) stat_gnt1_q <= stat_gnt1_q + 16'd1;
            if (stalled && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 16'd1;
        end
    end

    assign stat_gnt0  = stat_gnt0_q;
    assign stat_gnt1  = stat_gnt1_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule
